// File: rtl/pipelined_addsub.sv
// pipelined_addsub: segmented carry-chained adder/subtractor, one SEG-bit slice per stage,
// with valid/ready handshakes and carry/overflow/zero flags registered alongside the sum.
module pipelined_addsub #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NSEG = WIDTH / SEG;

    if (WIDTH % SEG != 0) begin : g_bad
        $error("pipelined_addsub: WIDTH must be a multiple of SEG");
    end

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    genvar k;
    for (k = 0; k < NSEG; k++) begin : g_st
        localparam int HI = WIDTH - k * SEG;
        logic [HI-1:0]          ai, bi;
        logic                   ci, vi;
        logic [SEG:0]           r;
        logic [(k+1)*SEG-1:0]   sn, s_q;
        logic                   c_q, v_q;
        if (k == 0) begin : g_in
            assign ai = a;
            assign bi = sub ? ~b : b;
            assign ci = sub ? 1'b1 : cin;
            assign vi = in_valid;
            assign sn = r[SEG-1:0];
        end else begin : g_chain
            assign ai = g_st[k-1].g_fwd.a_q;
            assign bi = g_st[k-1].g_fwd.b_q;
            assign ci = g_st[k-1].c_q;
            assign vi = g_st[k-1].v_q;
            assign sn = {r[SEG-1:0], g_st[k-1].s_q};
        end
        assign r = {1'b0, ai[SEG-1:0]} + {1'b0, bi[SEG-1:0]} + {{SEG{1'b0}}, ci};
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= vi;
                c_q <= r[SEG];
                s_q <= sn;
            end
        end
        if (k < NSEG - 1) begin : g_fwd
            logic [HI-SEG-1:0] a_q, b_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= ai[HI-1:SEG];
                    b_q <= bi[HI-1:SEG];
                end
            end
        end else begin : g_fin
            // carry into the MSB is a^b^sum at that bit; xor with carry out gives overflow
            logic ovf_q, zero_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (adv) begin
                    ovf_q  <= ai[SEG-1] ^ bi[SEG-1] ^ r[SEG-1] ^ r[SEG];
                    zero_q <= ~|sn;
                end
            end
        end
    end

    assign out_valid = g_st[NSEG-1].v_q;
    assign sum       = g_st[NSEG-1].s_q;
    assign cout      = g_st[NSEG-1].c_q;
    assign ovf       = g_st[NSEG-1].g_fin.ovf_q;
    assign zero      = g_st[NSEG-1].g_fin.zero_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed vector table plus handshake sequences checked against a scoreboard.
module tb_pipelined_addsub;
    localparam int W = 32;
    localparam int S = 8;
    localparam int L = W / S;

    logic         clk = 1'b0, rst = 1'b1;
    logic         in_valid = 1'b0, cin = 1'b0, sub = 1'b0, out_ready = 1'b1;
    logic         in_ready, out_valid, cout, ovf, zero;
    logic [W-1:0] a = '0, b = '0, sum;
    int           n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(W), .SEG(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    typedef struct packed {
        logic [W-1:0] s;
        logic         c, o, z;
    } res_t;
    typedef struct {
        logic [W-1:0] a, b;
        logic         cin, sub;
        res_t         e;
    } vec_t;

    res_t q[$];

    function automatic res_t model(logic [W-1:0] x, logic [W-1:0] y, logic ci, logic sb);
        logic [W-1:0] yy;
        logic [W:0]   t;
        res_t         m;
        yy  = sb ? ~y : y;
        t   = {1'b0, x} + {1'b0, yy} + ((sb ? 1 : ci) ? 33'd1 : 33'd0);
        m.s = t[W-1:0];
        m.c = t[W];
        m.o = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
        m.z = (t[W-1:0] == '0);
        return m;
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // called at negedge+1 with inputs settled; records handshakes, then advances one cycle
    task automatic step();
        if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
        if (out_valid && out_ready) begin
            if (q.size() == 0) chk("sb_extra", 64'd1, 64'd0);
            else chk("sb", 64'({sum, cout, ovf, zero}), 64'(q.pop_front()));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t tv[10];

    initial begin
        int   lat, first, nv, i, ops;
        logic ir_ok, acc;
        res_t r0;
        tv[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, '{32'h00000000, 1'b1, 1'b0, 1'b1}};
        tv[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, '{32'h80000000, 1'b0, 1'b1, 1'b0}};
        tv[2] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, '{32'hFFFFFFFE, 1'b0, 1'b0, 1'b0}};
        tv[3] = '{32'h00000001, 32'h00000002, 1'b1, 1'b0, '{32'h00000004, 1'b0, 1'b0, 1'b0}};
        tv[4] = '{32'h00000007, 32'h00000007, 1'b0, 1'b1, '{32'h00000000, 1'b1, 1'b0, 1'b1}};
        tv[5] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, '{32'h7FFFFFFF, 1'b1, 1'b1, 1'b0}};
        tv[6] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, '{32'h00000000, 1'b1, 1'b1, 1'b1}};
        tv[7] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, '{32'h00000100, 1'b0, 1'b0, 1'b0}};
        tv[8] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, '{32'h00000000, 1'b1, 1'b0, 1'b1}};
        tv[9] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, '{32'hACF13568, 1'b0, 1'b0, 1'b0}};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_flags", 64'({cout, ovf, zero}), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // directed table: one bundle at a time, latency and result checked
        foreach (tv[n]) begin
            a = tv[n].a; b = tv[n].b; cin = tv[n].cin; sub = tv[n].sub;
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 20) begin
                @(posedge clk);
                @(negedge clk);
                lat++;
            end
            chk($sformatf("vec%0d_lat", n), 64'(lat), 64'(L));
            chk($sformatf("vec%0d_sum", n), 64'(sum), 64'(tv[n].e.s));
            chk($sformatf("vec%0d_cout", n), 64'(cout), 64'(tv[n].e.c));
            chk($sformatf("vec%0d_ovf", n), 64'(ovf), 64'(tv[n].e.o));
            chk($sformatf("vec%0d_zero", n), 64'(zero), 64'(tv[n].e.z));
        end
        @(posedge clk);
        @(negedge clk);

        // throughput: six back-to-back bundles, out_ready held high
        first = -1; nv = 0; ir_ok = 1'b1;
        cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            in_valid = (c < 6);
            a = W'(c + 1);
            b = W'(c + 1) * 32'h01010101;
            #1;
            if (in_ready !== 1'b1) ir_ok = 1'b0;
            if (out_valid) begin
                if (first < 0) first = c;
                nv++;
            end
            step();
        end
        chk("tp_first", 64'(first), 64'd4);
        chk("tp_count", 64'(nv), 64'd6);
        chk("tp_in_ready", 64'(ir_ok), 64'd1);
        chk("tp_drained", 64'(q.size()), 64'd0);

        // backpressure: full pipe, out_ready low for three cycles
        i = 0; cin = 1'b1;
        r0 = model(32'h000000F0, ~32'h0, 1'b1, 1'b0);
        for (int c = 0; c < 30; c++) begin
            in_valid  = (i < 8);
            a         = W'(i) * 32'h10203040 + 32'hF0;
            b         = ~W'(i);
            sub       = i[0];
            out_ready = !(c >= 4 && c < 7);
            #1;
            if (c >= 4 && c < 7) begin
                chk("bp_in_ready", 64'(in_ready), 64'd0);
                chk("bp_valid", 64'(out_valid), 64'd1);
                chk("bp_hold", 64'({sum, cout, ovf, zero}), 64'(r0));
            end
            acc = in_valid && in_ready;
            step();
            if (acc) i++;
        end
        chk("bp_drained", 64'(q.size() + (8 - i)), 64'd0);

        // random handshakes against the scoreboard
        ops = 0;
        for (int c = 0; c < 6000 && ops < 1000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            a = W'($urandom); b = W'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            #1;
            acc = in_valid && in_ready;
            step();
            if (acc) ops++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            step();
        end
        chk("rnd_ops", 64'(ops), 64'd1000);
        chk("rnd_drained", 64'(q.size()), 64'd0);

        // reset mid-flight
        cin = 1'b0; sub = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = (c < 3);
            a = W'(c + 5); b = W'(c + 9);
            #1;
            step();
        end
        in_valid = 1'b0;
        chk("mid_pre_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_valid", 64'(out_valid), 64'd0);
        chk("mid_sum", 64'(sum), 64'd0);
        chk("mid_flags", 64'({cout, ovf, zero}), 64'd0);
        #1 rst = 1'b0;
        q.delete();
        nv = 0;
        @(negedge clk);
        for (int c = 0; c < 8; c++) begin
            #1;
            if (out_valid) nv++;
            step();
        end
        chk("mid_no_stale", 64'(nv), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
